// File: rtl/code_conv_sched.sv
// Round-robin scheduler sharing one 4-bit code converter (bin/Gray, BCD/excess-3)
// among four requesters; one job in flight, result returned over valid/ack.
module code_conv_sched #(
  parameter int LAT   = 2,
  parameter int N_REQ = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [7:0]  req_mode,
  input  logic [15:0] req_data,
  output logic [3:0]  gnt,
  output logic        busy,
  output logic        resp_valid,
  output logic [1:0]  resp_id,
  output logic [3:0]  resp_data,
  output logic        resp_err,
  input  logic        resp_ack
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_rr;
  logic [1:0] r_mode;
  logic [3:0] r_opnd;
  logic [3:0] r_cnt;
  logic [1:0] w_winner;
  logic       w_found;
  logic [3:0] w_conv_data;
  logic       w_conv_err;

  // First set request at or above the rr pointer, wrapping modulo 4.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_rr;
    for (int k = 0; k < 4; k++) begin
      if (!w_found && req[2'(r_rr + 2'(k))]) begin
        w_found  = 1'b1;
        w_winner = 2'(r_rr + 2'(k));
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (|req) w_next = CONV;
      CONV:    if (r_cnt == 4'd0) w_next = DONE;
      DONE:    if (resp_ack) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Invalid operands report an error with a zeroed result.
  always_comb begin
    w_conv_data = 4'd0;
    w_conv_err  = 1'b0;
    case (r_mode)
      2'b00: w_conv_data = r_opnd ^ {1'b0, r_opnd[3:1]};
      2'b01: w_conv_data = {r_opnd[3],
                            r_opnd[3] ^ r_opnd[2],
                            r_opnd[3] ^ r_opnd[2] ^ r_opnd[1],
                            r_opnd[3] ^ r_opnd[2] ^ r_opnd[1] ^ r_opnd[0]};
      2'b10: begin
        if (r_opnd <= 4'd9) w_conv_data = r_opnd + 4'd3;
        else                w_conv_err  = 1'b1;
      end
      default: begin
        if (r_opnd >= 4'd3 && r_opnd <= 4'd12) w_conv_data = r_opnd - 4'd3;
        else                                   w_conv_err  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt        <= 4'd0;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
      resp_id    <= 2'd0;
      resp_data  <= 4'd0;
      resp_err   <= 1'b0;
      r_rr       <= 2'd0;
      r_mode     <= 2'd0;
      r_opnd     <= 4'd0;
      r_cnt      <= 4'd0;
    end else begin
      busy <= (w_next != IDLE);
      gnt  <= 4'd0;
      case (r_state)
        IDLE: begin
          if (|req) begin
            gnt     <= 4'b0001 << w_winner;
            r_mode  <= req_mode[{w_winner, 1'b0} +: 2];
            r_opnd  <= req_data[{w_winner, 2'b00} +: 4];
            resp_id <= w_winner;
            r_cnt   <= 4'(LAT - 1);
            r_rr    <= w_winner + 2'd1;
          end
        end
        CONV: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            resp_data  <= w_conv_data;
            resp_err   <= w_conv_err;
            resp_valid <= 1'b1;
          end
        end
        DONE: begin
          if (resp_ack) resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_code_conv_sched.sv
// Directed bench for code_conv_sched: conversions, error cases, round-robin order,
// back-pressure hold and reset during a conversion.
module tb_code_conv_sched;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [7:0]  req_mode;
  logic [15:0] req_data;
  logic [3:0]  gnt;
  logic        busy;
  logic        resp_valid;
  logic [1:0]  resp_id;
  logic [3:0]  resp_data;
  logic        resp_err;
  logic        resp_ack;

  int total = 0;
  int bad   = 0;
  int gIdx[5];
  int gCyc[5];
  int ng;

  code_conv_sched #(.LAT(LAT), .N_REQ(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_mode(req_mode), .req_data(req_data),
    .gnt(gnt), .busy(busy), .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_data(resp_data), .resp_err(resp_err), .resp_ack(resp_ack)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int oneHotIdx(input logic [3:0] g);
    case (g)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic applyStimulus(input int id, input logic [1:0] mode, input logic [3:0] data);
    req                 = 4'b0001 << id;
    req_mode[2*id +: 2] = mode;
    req_data[4*id +: 4] = data;
  endtask

  task automatic waitGnt(input string tag, input logic [3:0] expGnt);
    bit got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      tick();
      if (gnt != 4'd0) got = 1;
    end
    checkOutput({tag, "_gnt"}, 16'(gnt), 16'(expGnt));
  endtask

  task automatic waitValid(input string tag);
    for (int n = 0; n < 20 && !resp_valid; n++) tick();
    checkOutput({tag, "_valid"}, 16'(resp_valid), 16'd1);
  endtask

  task automatic ackResult(input string tag);
    resp_ack = 1'b1;
    tick();
    resp_ack = 1'b0;
    checkOutput({tag, "_ackValid"}, 16'(resp_valid), 16'd0);
    checkOutput({tag, "_ackBusy"}, 16'(busy), 16'd0);
  endtask

  task automatic runJob(input string tag, input int id, input logic [1:0] mode,
                        input logic [3:0] data, input logic [3:0] expData, input logic expErr);
    @(negedge clk);
    applyStimulus(id, mode, data);
    waitGnt(tag, 4'b0001 << id);
    req = 4'd0;
    if (gnt != 4'd0) begin
      for (int k = 1; k <= LAT; k++) begin
        tick();
        if (k == 1) checkOutput({tag, "_gntPulse"}, 16'(gnt), 16'd0);
        if (k < LAT) checkOutput({tag, "_early"}, 16'(resp_valid), 16'd0);
      end
      checkOutput({tag, "_valid"}, 16'(resp_valid), 16'd1);
      checkOutput({tag, "_id"}, 16'(resp_id), 16'(id));
      checkOutput({tag, "_data"}, 16'(resp_data), 16'(expData));
      checkOutput({tag, "_err"}, 16'(resp_err), 16'(expErr));
      checkOutput({tag, "_busy"}, 16'(busy), 16'd1);
      ackResult(tag);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_gnt"}, 16'(gnt), 16'd0);
    checkOutput({tag, "_busy"}, 16'(busy), 16'd0);
    checkOutput({tag, "_valid"}, 16'(resp_valid), 16'd0);
    checkOutput({tag, "_id"}, 16'(resp_id), 16'd0);
    checkOutput({tag, "_data"}, 16'(resp_data), 16'd0);
    checkOutput({tag, "_err"}, 16'(resp_err), 16'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; req = 4'd0; req_mode = 8'd0; req_data = 16'd0; resp_ack = 1'b0;
    tick();
    tick();
    checkResetState("reset");
    rst = 1'b0;

    runJob("bin2gray", 0, 2'b00, 4'b1011, 4'b1110, 1'b0);
    runJob("gray2bin", 1, 2'b01, 4'b1110, 4'b1011, 1'b0);
    runJob("bcd2ex3",  2, 2'b10, 4'b0111, 4'b1010, 1'b0);
    runJob("ex32bcd",  3, 2'b11, 4'b1100, 4'b1001, 1'b0);
    runJob("errBcd",   2, 2'b10, 4'b1101, 4'b0000, 1'b1);
    runJob("errEx3",   3, 2'b11, 4'b0010, 4'b0000, 1'b1);
    runJob("bcdMax",   0, 2'b10, 4'b1001, 4'b1100, 1'b0);
    runJob("ex3Min",   1, 2'b11, 4'b0011, 4'b0000, 1'b0);
    runJob("ex3Over",  1, 2'b11, 4'b1101, 4'b0000, 1'b1);

    // Round-robin with all requesters held high and immediate ack.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_mode = 8'd0;
    req_data = 16'h4321;
    req = 4'b1111;
    ng = 0;
    for (int c = 0; c < 60 && ng < 5; c++) begin
      tick();
      if (gnt != 4'd0) begin
        gIdx[ng] = oneHotIdx(gnt);
        gCyc[ng] = c;
        ng++;
        if (ng == 5) req = 4'd0;
      end
      resp_ack = resp_valid;
    end
    resp_ack = 1'b0;
    checkOutput("rr_count", 16'(ng), 16'd5);
    for (int i = 0; i < ng; i++) begin
      checkOutput($sformatf("rr_order%0d", i), 16'(gIdx[i]), 16'(i % 4));
      if (i > 0) checkOutput($sformatf("rr_space%0d", i), 16'(gCyc[i] - gCyc[i-1]), 16'(LAT + 2));
    end
    waitValid("rr_last");
    checkOutput("rr_lastData", 16'(resp_data), 16'h0001);
    ackResult("rr_last");

    // Back-pressure: result must hold while inputs churn and ack stays low.
    @(negedge clk);
    applyStimulus(2, 2'b00, 4'b0011);
    waitGnt("hold", 4'b0100);
    req = 4'd0;
    waitValid("hold");
    for (int i = 0; i < 10; i++) begin
      req      = 4'b1111;
      req_mode = 8'($urandom);
      req_data = 16'($urandom);
      tick();
      checkOutput("hold_valid", 16'(resp_valid), 16'd1);
      checkOutput("hold_id", 16'(resp_id), 16'd2);
      checkOutput("hold_data", 16'(resp_data), 16'b0010);
      checkOutput("hold_err", 16'(resp_err), 16'd0);
      checkOutput("hold_gnt", 16'(gnt), 16'd0);
    end
    req = 4'b1011;
    req_mode[7:6] = 2'b11;
    req_data[15:12] = 4'b0101;
    resp_ack = 1'b1;
    tick();
    resp_ack = 1'b0;
    checkOutput("hold_ackValid", 16'(resp_valid), 16'd0);
    tick();
    checkOutput("hold_nextGnt", 16'(gnt), 16'b1000);
    req = 4'd0;
    waitValid("hold_next");
    checkOutput("hold_nextId", 16'(resp_id), 16'd3);
    checkOutput("hold_nextData", 16'(resp_data), 16'b0010);
    ackResult("hold_next");

    // Reset while a conversion is in flight.
    @(negedge clk);
    applyStimulus(1, 2'b00, 4'b0001);
    waitGnt("midRst", 4'b0010);
    req = 4'd0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkResetState("midRst");
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("midRst_noValid", 16'(resp_valid), 16'd0);
    end
    @(negedge clk);
    req_mode = 8'd0;
    req_data = 16'h0504;
    req = 4'b0101;
    waitGnt("rrAfterRst", 4'b0001);
    req = 4'd0;
    waitValid("rrAfterRst");
    checkOutput("rrAfterRst_data", 16'(resp_data), 16'b0110);
    ackResult("rrAfterRst");
    runJob("req2AfterRst", 2, 2'b01, 4'b0010, 4'b0011, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/code_conv_sched.md
Name: code_conv_sched

Overview:
Scheduler that shares one 4-bit code-conversion unit among 4 requesters. The unit supports binary↔Gray and BCD↔excess-3 conversion.
Round-robin arbitration picks one requester and latches its operand and mode. The block holds the job for a programmable number of busy cycles, then returns a tagged result over a valid/ack handshake.
It sits between the lab's requester blocks and the conversion datapath, so only one conversion is in flight at a time.

Parameters:
LAT, 2, busy cycles per conversion (legal range 1..15)
N_REQ, 4, number of requesters (fixed at 4; other values unsupported)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
req  input  4  per-requester request; held high until that requester's gnt pulse
req_mode  input  8  2 bits per requester, [2i+1:2i]: 00 bin→Gray, 01 Gray→bin, 10 BCD→ex3, 11 ex3→BCD
req_data  input  16  4 bits per requester, [4i+3:4i], operand
gnt  output  4  one-hot registered grant; one-cycle pulse
busy  output  1  high when state is not IDLE
resp_valid  output  1  result available
resp_id  output  2  index of the requester that owns the result
resp_data  output  4  converted code
resp_err  output  1  operand invalid for the selected mode
resp_ack  input  1  consumer accepts the result

Behaviour:
- Reset (synchronous, rst sampled high at a clk edge): state=IDLE, gnt=0, busy=0, resp_valid=0, resp_id=0, resp_data=0, resp_err=0, rr pointer=0, busy counter=0.
- Reset mid-operation: the in-flight job is dropped and no response is produced. The requester must re-request.
- States: IDLE, CONV, DONE.
- IDLE:
  - If req!=0 at an edge (the capture edge E0): winner = first set bit of req, searching from the rr pointer upward modulo 4.
  - At E0: gnt<=onehot(winner); mode and operand of the winner are latched; resp_id<=winner; counter<=LAT-1; rr pointer<=(winner+1) mod 4; state→CONV.
  - If req==0: stay in IDLE, gnt=0.
- CONV:
  - gnt clears at the first edge after E0, so gnt is high for exactly one cycle.
  - While counter!=0: decrement at each edge.
  - At the edge where counter==0: resp_data/resp_err are loaded from the latched operand and resp_valid<=1; state→DONE.
  - Result: resp_valid is visible after edge E0+LAT.
  - req, req_mode and req_data changes during CONV and DONE are ignored.
- DONE:
  - resp_valid, resp_id, resp_data and resp_err hold stable until resp_ack is sampled high.
  - On ack: resp_valid<=0; state→IDLE. resp_data/resp_id/resp_err keep their last values.
  - Ack in the first DONE cycle is legal. resp_ack outside DONE is ignored.
- Throughput: at least one IDLE cycle between jobs (no bypass). Maximum throughput is one job per LAT+2 cycles.
- Conversion rules (operand x, result y):
  - 00: y = x ^ (x>>1).
  - 01: y3=x3, yi = y(i+1) ^ xi.
  - 10: valid if x≤9; y = x+3 (4-bit).
  - 11: valid if 3≤x≤12; y = x-3.
  - Invalid operand: resp_err=1, resp_data=0.
- Requester contract: keep req, mode and data stable until gnt, then drop req in the cycle after gnt. A req still high after its gnt is treated as a new request.
- busy = (state!=IDLE), registered.

Test Plan:
- After reset, req=0001, mode0=00, data0=1011 → gnt=0001 for 1 cycle; after E0+2, resp_valid=1, resp_id=0, resp_data=1110, resp_err=0; ack → IDLE next edge.
- Requester 1: mode=01, data=1110 → resp_data=1011. Requester 2: mode=10, data=0111 → resp_data=1010. Requester 3: mode=11, data=1100 → resp_data=1001.
- Error cases: mode 10, data=1101 → resp_err=1, resp_data=0000. Mode 11, data=0010 → resp_err=1.
- All four req held high continuously from reset, acking each result immediately → grant order 0,1,2,3,0; gnt spacing = LAT+2 = 4 cycles.
- Hold resp_ack=0 for 10 cycles in DONE, changing req/req_data meanwhile → resp_* stable, no new gnt; ack → next grant goes to the rr-pointer requester.
- Assert rst for 1 cycle during CONV → all outputs 0, state IDLE, no resp_valid, rr pointer=0; the next request from requester 2 alone is granted normally.
